// File: rtl/icache_axi_rd.sv
// Read-only AXI4 master for icache line fills and uncached fetches.
// One request at a time: AR burst, R beats collected into a 256-bit line, one-cycle return pulse.
module icache_axi_rd #(
  parameter logic [3:0]  AXI_ID     = 4'd0,
  parameter int unsigned LINE_BEATS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         rd_req,
  input  logic         rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [255:0] ret_data,
  output logic         ret_err,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  localparam int unsigned BEAT_W = 32;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned IDLE_B = 0;
  localparam int unsigned AR_B   = 1;
  localparam int unsigned R_B    = 2;
  localparam int unsigned RET_B  = 3;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_AR   = 4'b0010,
    S_R    = 4'b0100,
    S_RET  = 4'b1000
  } state_t;

  state_t                              state;
  logic [31:0]                         addr_q;
  logic                                type_q;
  logic [CNT_W-1:0]                    beat_cnt;
  logic                                err_q;
  logic [LINE_BEATS-1:0][BEAT_W-1:0]   line_buf;
  logic [CNT_W-1:0]                    last_idx_c;
  logic                                unused_rid;

  // Only one burst is ever in flight, so the returned ID carries no information.
  assign unused_rid = ^rid;

  assign last_idx_c = type_q ? CNT_W'(LINE_BEATS - 1) : '0;

  // One-hot state bits double as the handshake outputs.
  assign rd_rdy    = state[IDLE_B];
  assign arvalid   = state[AR_B];
  assign rready    = state[R_B];
  assign ret_valid = state[RET_B];

  assign arid    = AXI_ID;
  assign arsize  = 3'b010;
  assign arburst = 2'b01;
  assign araddr  = type_q ? {addr_q[31:5], 5'b0} : addr_q;
  assign arlen   = type_q ? 8'(LINE_BEATS - 1) : 8'd0;

  // Line buffer and error flag persist after RET until the next request is taken.
  assign ret_data = line_buf;
  assign ret_err  = err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      addr_q   <= '0;
      type_q   <= 1'b0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      line_buf <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (rd_req) begin
            addr_q   <= rd_addr;
            type_q   <= rd_type;
            beat_cnt <= '0;
            err_q    <= 1'b0;
            line_buf <= '0;
            state    <= S_AR;
          end
        end
        S_AR: begin
          if (arready) state <= S_R;
        end
        S_R: begin
          if (rvalid) begin
            line_buf[beat_cnt] <= rdata;
            beat_cnt           <= beat_cnt + CNT_W'(1);
            err_q              <= err_q | (rresp != 2'b00);
            if (rlast || (beat_cnt == last_idx_c)) state <= S_RET;
          end
        end
        S_RET: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
